// File: rtl/flash_seq.sv
// AMD-style JEDEC command sequencer for the NeoGS boot flash: expands one high-level op into
// unlock/command writes on the rom controller port, then polls DQ6 toggle / DQ5 for completion.
module flash_seq #(
   parameter int          TMO_W   = 24,
   parameter logic [18:0] UNLK_A1 = 19'h555,
   parameter logic [18:0] UNLK_A2 = 19'h2AA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   input  logic [18:0] cmd_addr,
   input  logic [7:0]  cmd_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        rom_req,
   output logic        rom_we,
   output logic [18:0] rom_addr,
   output logic [7:0]  rom_wdata,
   input  logic [7:0]  rom_rdata,
   input  logic        rom_ack
);

   localparam logic [1:0] OP_PROG   = 2'd0;
   localparam logic [1:0] OP_SERASE = 2'd1;
   localparam logic [1:0] OP_CERASE = 2'd2;
   localparam logic [1:0] OP_RST    = 2'd3;
   localparam logic [TMO_W-1:0] TMO_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_WSEQ, S_POLL1, S_POLL2, S_CHK5, S_ABORT, S_DONE
   } state_t;

   state_t            state, state_n;
   logic [1:0]        op_q, op_n;
   logic [18:0]       addr_q, addr_n;
   logic [7:0]        data_q, data_n;
   logic [2:0]        step_q, step_n;
   logic [TMO_W-1:0]  pcnt_q, pcnt_n, pcnt_inc;
   logic [7:0]        r1_q, r1_n;
   logic              chk_q, chk_n;
   logic              err_n;
   logic              rom_req_n, rom_we_n;
   logic [18:0]       rom_addr_n;
   logic [7:0]        rom_wdata_n;

   logic              acked;
   logic              acc_en, acc_we;
   logic [18:0]       acc_addr;
   logic [7:0]        acc_wdata;
   logic [18:0]       seq_addr, poll_addr;
   logic [7:0]        seq_data;
   logic [2:0]        seq_last;

   assign acked     = rom_req & rom_ack;
   assign poll_addr = (op_q == OP_CERASE) ? UNLK_A1 : addr_q;
   assign pcnt_inc  = (pcnt_q == TMO_MAX) ? pcnt_q : pcnt_q + TMO_W'(1);
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);

   // Command table: step_q indexes the unlock/command write sequence of the latched op
   always_comb begin
      seq_addr = UNLK_A1;
      seq_data = 8'hF0;
      seq_last = 3'd5;
      case (step_q)
         3'd0: begin seq_addr = UNLK_A1; seq_data = 8'hAA; end
         3'd1: begin seq_addr = UNLK_A2; seq_data = 8'h55; end
         3'd2: begin seq_addr = UNLK_A1; seq_data = (op_q == OP_PROG) ? 8'hA0 : 8'h80; end
         3'd3: begin
            seq_addr = (op_q == OP_PROG) ? addr_q : UNLK_A1;
            seq_data = (op_q == OP_PROG) ? data_q : 8'hAA;
         end
         3'd4: begin seq_addr = UNLK_A2; seq_data = 8'h55; end
         default: begin
            seq_addr = (op_q == OP_SERASE) ? addr_q : UNLK_A1;
            seq_data = (op_q == OP_SERASE) ? 8'h30 : 8'h10;
         end
      endcase
      if (op_q == OP_RST) begin
         seq_addr = UNLK_A1;
         seq_data = 8'hF0;
         seq_last = 3'd0;
      end else if (op_q == OP_PROG) begin
         seq_last = 3'd3;
      end
   end

   always_comb begin
      state_n     = state;
      op_n        = op_q;
      addr_n      = addr_q;
      data_n      = data_q;
      step_n      = step_q;
      pcnt_n      = pcnt_q;
      r1_n        = r1_q;
      chk_n       = chk_q;
      err_n       = err;
      rom_req_n   = rom_req;
      rom_we_n    = rom_we;
      rom_addr_n  = rom_addr;
      rom_wdata_n = rom_wdata;
      acc_en      = 1'b0;
      acc_we      = 1'b0;
      acc_addr    = '0;
      acc_wdata   = '0;

      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               op_n    = cmd_op;
               addr_n  = cmd_addr;
               data_n  = cmd_data;
               step_n  = '0;
               pcnt_n  = '0;
               chk_n   = 1'b0;
               err_n   = 1'b0;
               state_n = S_WSEQ;
            end
         end
         S_WSEQ: begin
            acc_en    = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = seq_addr;
            acc_wdata = seq_data;
            if (acked) begin
               if (step_q == seq_last)
                  state_n = (op_q == OP_RST) ? S_DONE : S_POLL1;
               else
                  step_n = step_q + 3'd1;
            end
         end
         S_POLL1: begin
            acc_en   = 1'b1;
            acc_addr = poll_addr;
            if (acked) begin
               r1_n    = rom_rdata;
               state_n = S_POLL2;
            end
         end
         S_POLL2: begin
            acc_en   = 1'b1;
            acc_addr = poll_addr;
            if (acked) begin
               pcnt_n = pcnt_inc;
               // A stable DQ6 wins over timeout; timeout wins over the DQ5 check
               if (r1_q[6] == rom_rdata[6]) begin
                  state_n = S_DONE;
               end else if (pcnt_inc == TMO_MAX) begin
                  state_n = S_ABORT;
               end else if (rom_rdata[5]) begin
                  chk_n   = 1'b0;
                  state_n = S_CHK5;
               end else begin
                  state_n = S_POLL1;
               end
            end
         end
         S_CHK5: begin
            acc_en   = 1'b1;
            acc_addr = poll_addr;
            if (acked) begin
               if (!chk_q) begin
                  r1_n  = rom_rdata;
                  chk_n = 1'b1;
               end else begin
                  state_n = (r1_q[6] == rom_rdata[6]) ? S_DONE : S_ABORT;
               end
            end
         end
         S_ABORT: begin
            acc_en    = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = UNLK_A1;
            acc_wdata = 8'hF0;
            if (acked) begin
               err_n   = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // Shared access handshake: issue after an idle cycle, hold until ack, drop right after
      if (acc_en) begin
         if (!rom_req) begin
            rom_req_n   = 1'b1;
            rom_we_n    = acc_we;
            rom_addr_n  = acc_addr;
            rom_wdata_n = acc_wdata;
         end else if (rom_ack) begin
            rom_req_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= OP_PROG;
         addr_q    <= '0;
         data_q    <= '0;
         step_q    <= '0;
         pcnt_q    <= '0;
         r1_q      <= '0;
         chk_q     <= 1'b0;
         err       <= 1'b0;
         rom_req   <= 1'b0;
         rom_we    <= 1'b0;
         rom_addr  <= '0;
         rom_wdata <= '0;
      end else begin
         state     <= state_n;
         op_q      <= op_n;
         addr_q    <= addr_n;
         data_q    <= data_n;
         step_q    <= step_n;
         pcnt_q    <= pcnt_n;
         r1_q      <= r1_n;
         chk_q     <= chk_n;
         err       <= err_n;
         rom_req   <= rom_req_n;
         rom_we    <= rom_we_n;
         rom_addr  <= rom_addr_n;
         rom_wdata <= rom_wdata_n;
      end
   end

endmodule

// File: tb/tb_flash_seq.sv
// Randomized bench for flash_seq: a flash/rom responder plus a behavioural model of the
// expected access list and outcome for each op.
module tb_flash_seq;

   localparam int          TMO_W = 4;
   localparam int          PMAX  = (1 << TMO_W) - 1;
   localparam logic [18:0] A1    = 19'h555;
   localparam logic [18:0] A2    = 19'h2AA;
   localparam int          FOREVER_TOG = 100000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [18:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic        busy, done, err;
   logic        rom_req, rom_we;
   logic [18:0] rom_addr;
   logic [7:0]  rom_wdata;
   logic [7:0]  rom_rdata;
   logic        rom_ack;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [27:0] exp_q[$];
   logic [27:0] obs_q[$];
   int          cur_tog = 0;
   bit          cur_dq5 = 1'b0;
   int          rd_idx = 0;
   int          lat_lo = 0;
   int          lat_hi = 0;
   bit          spur_en = 1'b0;
   int          done_cnt = 0;

   flash_seq #(.TMO_W(TMO_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rom_req   (rom_req),
      .rom_we    (rom_we),
      .rom_addr  (rom_addr),
      .rom_wdata (rom_wdata),
      .rom_rdata (rom_rdata),
      .rom_ack   (rom_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Flash status byte for the i-th poll read: DQ6 toggles for the first tog reads, then freezes
   function automatic logic [7:0] rd_val(input int i, input int tog, input bit dq5);
      int   j;
      logic dq6;
      j   = i;
      dq6 = (i < tog) ? j[0] : tog[0];
      return {1'b0, dq6, dq5, 5'(i)};
   endfunction

   function automatic logic [27:0] tx(input logic we, input logic [18:0] a, input logic [7:0] d);
      return {we, a, d};
   endfunction

   task automatic build_exp(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d,
                            input int tog, input bit dq5, output bit exp_done);
      logic [18:0] pa;
      logic [7:0]  x, y;
      int          rd, pairs;
      exp_q.delete();
      exp_done = 1'b1;
      if (op == 2'd3) begin
         exp_q.push_back(tx(1'b1, A1, 8'hF0));
         return;
      end
      exp_q.push_back(tx(1'b1, A1, 8'hAA));
      exp_q.push_back(tx(1'b1, A2, 8'h55));
      if (op == 2'd0) begin
         exp_q.push_back(tx(1'b1, A1, 8'hA0));
         exp_q.push_back(tx(1'b1, a, d));
      end else begin
         exp_q.push_back(tx(1'b1, A1, 8'h80));
         exp_q.push_back(tx(1'b1, A1, 8'hAA));
         exp_q.push_back(tx(1'b1, A2, 8'h55));
         exp_q.push_back((op == 2'd1) ? tx(1'b1, a, 8'h30) : tx(1'b1, A1, 8'h10));
      end
      pa    = (op == 2'd2) ? A1 : a;
      rd    = 0;
      pairs = 0;
      while (1) begin
         x = rd_val(rd, tog, dq5);
         y = rd_val(rd + 1, tog, dq5);
         rd += 2;
         pairs++;
         exp_q.push_back(tx(1'b0, pa, 8'h00));
         exp_q.push_back(tx(1'b0, pa, 8'h00));
         if (x[6] == y[6]) break;
         if (pairs >= PMAX) begin exp_done = 1'b0; break; end
         if (y[5]) begin
            x = rd_val(rd, tog, dq5);
            y = rd_val(rd + 1, tog, dq5);
            rd += 2;
            exp_q.push_back(tx(1'b0, pa, 8'h00));
            exp_q.push_back(tx(1'b0, pa, 8'h00));
            if (x[6] != y[6]) exp_done = 1'b0;
            break;
         end
      end
      if (!exp_done) exp_q.push_back(tx(1'b1, A1, 8'hF0));
   endtask

   // Rom controller / flash responder
   initial begin : rom_model
      int          wcnt;
      int          lat;
      bit          pend;
      logic [27:0] hold;
      rom_ack   = 1'b0;
      rom_rdata = 8'h00;
      wcnt = 0; lat = 0; pend = 1'b0; hold = '0;
      forever begin
         @(negedge clk);
         if (rom_ack) begin
            rom_ack = 1'b0;
            if (pend) check("gap", {31'd0, rom_req}, 32'd0);
            pend = 1'b0;
            wcnt = 0;
         end else if (!rom_req) begin
            pend = 1'b0;
            wcnt = 0;
            if (spur_en && $urandom_range(0, 7) == 0) rom_ack = 1'b1;
         end else begin
            if (!pend) begin
               pend = 1'b1;
               hold = {rom_we, rom_addr, rom_wdata};
               lat  = int'($urandom_range(lat_hi, lat_lo));
            end else begin
               check("hold", {4'd0, rom_we, rom_addr, rom_wdata}, {4'd0, hold});
            end
            if (wcnt >= lat) begin
               rom_ack = 1'b1;
               if (!rom_we) begin
                  rom_rdata = rd_val(rd_idx, cur_tog, cur_dq5);
                  rd_idx++;
               end
               obs_q.push_back({rom_we, rom_addr, rom_we ? rom_wdata : 8'h00});
            end else begin
               wcnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         check("done_busy", {31'd0, busy}, 32'd0);
      end
   end

   task automatic run_op(input string nm, input logic [1:0] op, input logic [18:0] a,
                         input logic [7:0] d, input int tog, input bit dq5, input bit ghost);
      bit exp_done;
      int cyc;
      int n;
      build_exp(op, a, d, tog, dq5, exp_done);
      obs_q.delete();
      rd_idx   = 0;
      cur_tog  = tog;
      cur_dq5  = dq5;
      done_cnt = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      @(negedge clk);
      check({nm, "_busy"}, {31'd0, busy}, 32'd1);
      check({nm, "_errclr"}, {31'd0, err}, 32'd0);
      if (ghost) begin
         cmd_op   = 2'd3;
         cmd_addr = 19'($urandom);
         cmd_data = 8'($urandom);
         repeat (2) @(negedge clk);
      end
      cmd_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check({nm, "_finish"}, {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check({nm, "_ntx"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_tx%0d", nm, i), {4'd0, obs_q[i]}, {4'd0, exp_q[i]});
      check({nm, "_done"}, done_cnt, {31'd0, exp_done});
      check({nm, "_err"}, {31'd0, err}, {31'd0, !exp_done});
   endtask

   initial begin : main
      int cyc;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_addr  = '0;
      cmd_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_req", {31'd0, rom_req}, 32'd0);
      check("rst_addr", {13'd0, rom_addr}, 32'd0);
      rst_n = 1'b1;

      run_op("prog", 2'd0, 19'h12345, 8'h5A, 0, 1'b0, 1'b0);
      lat_hi = 2;
      run_op("serase", 2'd1, 19'h30000, 8'h00, 10, 1'b0, 1'b0);
      run_op("cerase_dq5", 2'd2, 19'h00000, 8'h00, FOREVER_TOG, 1'b1, 1'b0);

      // Reset while the third unlock write is outstanding
      lat_lo = 20; lat_hi = 20;
      obs_q.delete();
      rd_idx = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 19'h00077; cmd_data = 8'h11;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 0;
      #1;
      while (!(obs_q.size() == 2 && rom_req && !rom_ack) && cyc < 500) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("rst_mid_step", obs_q.size(), 2);
      check("rst_mid_addr", {13'd0, rom_addr}, {13'd0, A1});
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", {31'd0, rom_req}, 32'd0);
      check("rst_mid_we", {31'd0, rom_we}, 32'd0);
      check("rst_mid_addr0", {13'd0, rom_addr}, 32'd0);
      check("rst_mid_wdata", {24'd0, rom_wdata}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_err", {31'd0, err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      lat_lo = 0; lat_hi = 2;
      run_op("post_rst", 2'd0, 19'h4ABCD, 8'hC3, 3, 1'b0, 1'b0);

      run_op("timeout", 2'd0, 19'h01234, 8'h99, FOREVER_TOG, 1'b0, 1'b0);
      run_op("ghost", 2'd0, 19'h7FFFF, 8'hFF, 4, 1'b0, 1'b1);
      run_op("reset_op", 2'd3, 19'h00000, 8'h00, 0, 1'b0, 1'b0);

      spur_en = 1'b1;
      lat_hi  = 3;
      for (int k = 0; k < 20; k++) begin
         logic [1:0] rop;
         int         rtog;
         rop  = 2'($urandom_range(0, 3));
         rtog = ($urandom_range(0, 3) == 0) ? FOREVER_TOG : int'($urandom_range(0, 30));
         run_op($sformatf("rnd%0d", k), rop, 19'($urandom), 8'($urandom), rtog,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0) && (rop != 2'd3));
      end

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
